cache_read_ctrl: RTL and testbench
==================================

Name: cache_read_ctrl

Overview:
- Read-path controller sitting directly upstream of the direct-mapped cache datapath. It drives the datapath's check_hit/read_data/write_data strobes and its 15-bit address.
- On a miss it fetches the 4-word block from main memory as 4 single-word beats, assembles the line, then writes it into the cache and completes the read.
- Presents a simple request/ready interface to the CPU.

Parameters:
- ADDR_W, 15, byte-less word address width; bits [1:0] select the word in a block.
- DATA_W, 32, word width.
- STAT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  read request; sampled only in IDLE.
- cpu_addr  in  ADDR_W  read address; latched when the request is accepted.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_ready  out  1  one-cycle pulse when cpu_data is valid.
- cpu_data  out  DATA_W  read result; holds its value until the next cpu_ready.
- check_hit  out  1  to datapath: hit lookup strobe.
- read_data  out  1  to datapath: word read strobe.
- write_data  out  1  to datapath: block fill strobe.
- cache_addr  out  ADDR_W  to datapath: the latched request address.
- fill0, fill1, fill2, fill3  out  DATA_W each  to datapath: the block words.
- hit  in  1  from datapath; registered, valid the cycle after check_hit.
- cache_dout  in  DATA_W  from datapath; registered, valid the cycle after read_data.
- mem_rd_req  out  1  main-memory block read request; level signal.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- mem_valid  in  1  one beat of returned data.
- mem_rdata  in  DATA_W  beat data; beats arrive in word order 0,1,2,3.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE. All strobes, cpu_ready, cpu_busy and mem_rd_req =0. cpu_data=0, fill0..3=0, beat counter=0, latched address=0.
- Only one of check_hit/read_data/write_data is ever high in a cycle. Each is a one-cycle pulse.
- States and transitions:
  - IDLE: if cpu_req, latch cpu_addr, go to CHECK. Otherwise stay.
  - CHECK: check_hit=1; go to EVAL.
  - EVAL: sample hit. If 1, go to READ. If 0, go to MEMRD.
  - MEMRD: mem_rd_req=1. On each mem_valid, store mem_rdata into fill[beat] and increment the 2-bit beat counter. On the 4th beat, go to FILL; mem_rd_req is low from the next cycle.
  - FILL: write_data=1 with fill0..3 stable; clear the beat counter; go to READ.
  - READ: read_data=1; go to RESP.
  - RESP: cpu_data<=cache_dout, cpu_ready=1 (registered so both are valid together); go to IDLE.
- Hit latency: request accepted at edge T, cpu_ready high in the cycle after edge T+4. Miss latency = 4 + (cycles spent in MEMRD) + 1.
- cpu_req outside IDLE is ignored. It is not queued, including in RESP.
- mem_valid outside MEMRD is ignored; beats never write fill registers outside MEMRD.
- mem_valid may have gaps. mem_rd_req stays high until the 4th beat.
- cache_addr and mem_addr stay constant from acceptance until return to IDLE.
- Reset mid-miss: abort immediately. No write_data pulse, partial fill discarded, mem_rd_req low the next cycle.

Optional Feature:
- Macro CACHE_STATS_EN.
- With it: extra outputs hit_count and miss_count (STAT_W each, reset 0). Incremented in EVAL according to hit. Saturate at all-ones, no wrap.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then cpu_req with cpu_addr=15'h1004; datapath model returns hit=0.
  - Expect mem_rd_req=1 with mem_addr=15'h1004.
  - Feed beats A0,A1,A2,A3 → one write_data pulse with fill0..3=A0..A3.
  - Then read_data, then cpu_ready with cpu_data=A0.
- Repeat the read of 15'h1006 with the model returning hit=1.
  - Expect no mem_rd_req and cpu_ready exactly 4 cycles after acceptance.
  - cpu_data = word 2 from the model.
- Miss with 3-cycle gaps between beats.
  - mem_rd_req is held through the gaps.
  - Beat order is preserved in fill0..3.
  - Stray mem_valid after FILL does not change fill registers.
- Drive rst_n=0 after 2 of 4 beats.
  - Expect no write_data, mem_rd_req=0, cpu_busy=0 after the reset edge.
  - A following miss fills from beat 0.
- Hold cpu_req high continuously.
  - A new request is accepted only in the cycle after cpu_ready.
  - check_hit never overlaps read_data or write_data.
- With CACHE_STATS_EN and STAT_W=2: do 5 misses and 1 hit.
  - Expect miss_count=3 (saturated) and hit_count=1.

Source files
------------

// File: rtl/cache_read_ctrl.sv
// Read-path controller for a direct-mapped cache; CACHE_STATS_EN adds saturating hit/miss counters.
// Latency: hit -> cpu_ready 4 cycles after acceptance; miss -> 5 + cycles spent fetching the block.
// Backpressure: one request at a time; cpu_req is sampled only while idle, memory beats only while fetching.
module cache_read_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
`ifdef CACHE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_busy,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_data,

    output logic              check_hit,
    output logic              read_data,
    output logic              write_data,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] fill0,
    output logic [DATA_W-1:0] fill1,
    output logic [DATA_W-1:0] fill2,
    output logic [DATA_W-1:0] fill3,
    input  logic              hit,
    input  logic [DATA_W-1:0] cache_dout,

    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_MEMRD = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    logic [2:0]                  state_q, state_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [1:0]                  beat_q, beat_d;
    logic [3:0][DATA_W-1:0]      fill_q, fill_d;
    logic [DATA_W-1:0]           cpu_data_q, cpu_data_d;
    logic                        cpu_ready_q, cpu_ready_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        fill_d      = fill_q;
        cpu_data_d  = cpu_data_q;
        cpu_ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_EVAL;
            S_EVAL:  state_d = hit ? S_READ : S_MEMRD;
            S_MEMRD: begin
                // beats arrive in word order, so the counter doubles as the word index
                if (mem_valid) begin
                    fill_d[beat_q] = mem_rdata;
                    beat_d         = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                beat_d  = 2'd0;
                state_d = S_READ;
            end
            S_READ: state_d = S_RESP;
            S_RESP: begin
                cpu_data_d  = cache_dout;
                cpu_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beat_q      <= 2'd0;
            fill_q      <= '0;
            cpu_data_q  <= '0;
            cpu_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            fill_q      <= fill_d;
            cpu_data_q  <= cpu_data_d;
            cpu_ready_q <= cpu_ready_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        // counters stick at all-ones rather than wrapping
        if (state_q == S_EVAL) begin
            if (hit) begin
                if (hit_cnt_q != '1) begin
                    hit_cnt_d = hit_cnt_q + STAT_W'(1);
                end
            end else begin
                if (miss_cnt_q != '1) begin
                    miss_cnt_d = miss_cnt_q + STAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign cpu_busy   = (state_q != S_IDLE);
    assign cpu_ready  = cpu_ready_q;
    assign cpu_data   = cpu_data_q;

    assign check_hit  = (state_q == S_CHECK);
    assign read_data  = (state_q == S_READ);
    assign write_data = (state_q == S_FILL);
    assign cache_addr = addr_q;
    assign fill0      = fill_q[0];
    assign fill1      = fill_q[1];
    assign fill2      = fill_q[2];
    assign fill3      = fill_q[3];

    assign mem_rd_req = (state_q == S_MEMRD);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_cache_read_ctrl.sv
// Directed bench for cache_read_ctrl with a behavioural cache datapath and queued expectations.
module tb_cache_read_ctrl;
    localparam int AW = 15;
    localparam int DW = 32;

    typedef logic [3:0][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req, cpu_busy, cpu_ready;
    logic [AW-1:0] cpu_addr, cache_addr, mem_addr;
    logic [DW-1:0] cpu_data, fill0, fill1, fill2, fill3, cache_dout, mem_rdata;
    logic          check_hit, read_data, write_data, hit, mem_rd_req, mem_valid;
`ifdef CACHE_STATS_EN
    logic [1:0]    hit_count, miss_count;
`endif

    logic [DW-1:0] exp_q[$];
    blk_t          fill_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            wr_cnt = 0;
    logic          model_hit = 1'b0;
    logic [DW-1:0] dp_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    cache_read_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef CACHE_STATS_EN
        ,
        .STAT_W(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_busy(cpu_busy),
        .cpu_ready(cpu_ready), .cpu_data(cpu_data),
        .check_hit(check_hit), .read_data(read_data), .write_data(write_data),
        .cache_addr(cache_addr),
        .fill0(fill0), .fill1(fill1), .fill2(fill2), .fill3(fill3),
        .hit(hit), .cache_dout(cache_dout),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Datapath model: registered hit and read data, whole-line fill.
    always @(posedge clk) begin
        if (check_hit) hit <= model_hit;
        if (read_data) cache_dout <= dp_mem[cache_addr];
        if (write_data) begin
            dp_mem[{cache_addr[AW-1:2], 2'd0}] <= fill0;
            dp_mem[{cache_addr[AW-1:2], 2'd1}] <= fill1;
            dp_mem[{cache_addr[AW-1:2], 2'd2}] <= fill2;
            dp_mem[{cache_addr[AW-1:2], 2'd3}] <= fill3;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_hit | read_data | write_data)
            chk("strobe_onehot", 32'($countones({check_hit, read_data, write_data})), 32'd1);
        if (write_data) begin
            blk_t e;
            wr_cnt++;
            chk("fill_pending", 32'(fill_q.size() > 0), 32'd1);
            if (fill_q.size() > 0) begin
                e = fill_q.pop_front();
                chk("fill0", fill0, e[0]);
                chk("fill1", fill1, e[1]);
                chk("fill2", fill2, e[2]);
                chk("fill3", fill3, e[3]);
            end
        end
        if (cpu_ready) begin
            chk("ready_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("cpu_data", cpu_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic h);
        cpu_req   = 1'b1;
        cpu_addr  = a;
        model_hit = h;
        tick();
        cpu_req   = 1'b0;
    endtask

    task automatic wait_memrd();
        for (int i = 0; i < 20 && !mem_rd_req; i++) tick();
        chk("memrd_wait", 32'(mem_rd_req), 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60 && !cpu_ready; i++) tick();
        chk("ready_wait", 32'(cpu_ready), 32'd1);
    endtask

    task automatic feed_beats(input blk_t w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            mem_valid = 1'b1;
            mem_rdata = w[i];
            tick();
            mem_valid = 1'b0;
            if (i < n - 1) begin
                repeat (gap) begin
                    chk("rdreq_hold", 32'(mem_rd_req), 32'd1);
                    tick();
                end
            end
        end
    endtask

    task automatic run_miss(input logic [AW-1:0] a, input blk_t w, input int gap);
        fill_q.push_back(w);
        exp_q.push_back(w[a[1:0]]);
        issue(a, 1'b0);
        wait_memrd();
        chk("miss_mem_addr", 32'(mem_addr), 32'({a[AW-1:2], 2'b00}));
        feed_beats(w, 4, gap);
        wait_ready();
        tick();
    endtask

    initial begin
        blk_t a_blk, b_blk, c_blk, j_blk;
        int   wr_before;
        a_blk = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        b_blk = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        c_blk = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        j_blk = {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'h0BAD_0000};
        cpu_req = 1'b0; cpu_addr = '0; mem_valid = 1'b0; mem_rdata = '0;

        repeat (2) tick();
        chk("rst_busy", 32'(cpu_busy), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_strobes", 32'({check_hit, read_data, write_data}), 32'd0);
        chk("rst_memrd", 32'(mem_rd_req), 32'd0);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_fill", fill0 | fill1 | fill2 | fill3, 32'd0);
        chk("rst_addr", 32'(cache_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Miss on 0x1004, stepped cycle by cycle
        fill_q.push_back(a_blk);
        exp_q.push_back(a_blk[0]);
        issue(15'h1004, 1'b0);
        chk("m1_check_hit", 32'(check_hit), 32'd1);
        chk("m1_busy", 32'(cpu_busy), 32'd1);
        tick();
        chk("m1_eval_memrd", 32'(mem_rd_req), 32'd0);
        tick();
        chk("m1_memrd", 32'(mem_rd_req), 32'd1);
        chk("m1_mem_addr", 32'(mem_addr), 32'h1004);
        chk("m1_cache_addr", 32'(cache_addr), 32'h1004);
        feed_beats(a_blk, 4, 0);
        chk("m1_write", 32'(write_data), 32'd1);
        chk("m1_memrd_drop", 32'(mem_rd_req), 32'd0);
        tick();
        chk("m1_read", 32'(read_data), 32'd1);
        tick();
        chk("m1_resp_noready", 32'(cpu_ready), 32'd0);
        tick();
        chk("m1_ready", 32'(cpu_ready), 32'd1);
        tick();

        // Hit on 0x1006: ready exactly 4 cycles after acceptance
        exp_q.push_back(a_blk[2]);
        issue(15'h1006, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("h_noready", 32'(cpu_ready), 32'd0);
            chk("h_nomemrd", 32'(mem_rd_req), 32'd0);
            tick();
        end
        chk("h_ready", 32'(cpu_ready), 32'd1);
        tick();

        // Miss with gaps between beats, then stray beats after the fill
        fill_q.push_back(c_blk);
        exp_q.push_back(c_blk[3]);
        issue(15'h3003, 1'b0);
        wait_memrd();
        feed_beats(c_blk, 4, 3);
        chk("g_write", 32'(write_data), 32'd1);
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        mem_valid = 1'b0;
        wait_ready();
        chk("g_stray_f0", fill0, c_blk[0]);
        chk("g_stray_f3", fill3, c_blk[3]);
        tick();

        // Reset after two of four beats
        issue(15'h2001, 1'b0);
        wait_memrd();
        feed_beats(j_blk, 2, 0);
        wr_before = wr_cnt;
        rst_n = 1'b0;
        tick();
        chk("ra_busy", 32'(cpu_busy), 32'd0);
        chk("ra_memrd", 32'(mem_rd_req), 32'd0);
        chk("ra_fill", fill0 | fill1, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ra_no_write", 32'(wr_cnt), 32'(wr_before));
        run_miss(15'h2001, b_blk, 1);

        // cpu_req held high: next acceptance only after cpu_ready
        model_hit = 1'b1;
        cpu_addr  = 15'h1005;
        cpu_req   = 1'b1;
        repeat (3) exp_q.push_back(a_blk[1]);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("hold_check", 32'(check_hit), 32'd1);
            repeat (3) begin
                tick();
                chk("hold_no_check", 32'(check_hit), 32'd0);
            end
            tick();
            chk("hold_ready", 32'(cpu_ready), 32'd1);
            chk("hold_ready_nocheck", 32'(check_hit), 32'd0);
            if (k == 2) cpu_req = 1'b0;
            tick();
        end
        chk("hold_idle", 32'(cpu_busy), 32'd0);

`ifdef CACHE_STATS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("st_rst", 32'({hit_count, miss_count}), 32'd0);
        for (int i = 0; i < 5; i++) run_miss(AW'(15'h4000 + 4 * i), b_blk, 0);
        exp_q.push_back(b_blk[0]);
        issue(15'h4000, 1'b1);
        wait_ready();
        tick();
        chk("st_miss", 32'(miss_count), 32'd3);
        chk("st_hit", 32'(hit_count), 32'd1);
`endif

        repeat (3) tick();
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("fill_drained", 32'(fill_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
